// File: rtl/radix8_booth_multiplier.sv
// Signed 16x16->32 radix-8 Booth multiplier; Kogge-Stone adders for 3M and the final sum.
// Latency 2 edges, one pair per cycle; no backpressure, in_valid ripples unconditionally to out_valid.

module rb8_ks_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] g_nxt;
  logic [W-1:0] p_nxt;

  // After the last prefix level g[i] is the carry out of bit i, with cin folded into bit 0.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    g[0]  = g[0] | (p[0] & cin);
    g_nxt = '0;
    p_nxt = '0;
    for (int l = 0; (1 << l) < W; l++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = (1 << l); i < W; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_nxt[i] = p[i] & p[i - (1 << l)];
      end
      g = g_nxt;
      p = p_nxt;
    end
    sum = a ^ b ^ {g[W-2:0], cin};
  end
endmodule

module rb8_booth_row #(
  parameter int EW    = 18,
  parameter int PW    = 32,
  parameter int SHIFT = 0
) (
  input  logic [EW-1:0] m,
  input  logic [EW-1:0] m3,
  input  logic [3:0]    grp,
  output logic [PW-1:0] pp,
  output logic          neg
);
  typedef enum logic [2:0] {SEL_0, SEL_1M, SEL_2M, SEL_3M, SEL_4M} sel_e;

  sel_e         sel;
  logic [EW:0]  mag;
  logic [PW-1:0] wide;

  always_comb begin
    sel = SEL_0;
    neg = 1'b0;
    case (grp)
      4'b0001, 4'b0010: sel = SEL_1M;
      4'b0011, 4'b0100: sel = SEL_2M;
      4'b0101, 4'b0110: sel = SEL_3M;
      4'b0111:          sel = SEL_4M;
      4'b1000:          begin sel = SEL_4M; neg = 1'b1; end
      4'b1001, 4'b1010: begin sel = SEL_3M; neg = 1'b1; end
      4'b1011, 4'b1100: begin sel = SEL_2M; neg = 1'b1; end
      4'b1101, 4'b1110: begin sel = SEL_1M; neg = 1'b1; end
      default:          sel = SEL_0;
    endcase
  end

  // Sign-extend to full width before inverting so -(-4M) with M=-32768 stays exact.
  always_comb begin
    case (sel)
      SEL_1M:  mag = {m[EW-1], m};
      SEL_2M:  mag = {m, 1'b0};
      SEL_3M:  mag = {m3[EW-1], m3};
      SEL_4M:  mag = {m[EW-2:0], 2'b00};
      default: mag = '0;
    endcase
    wide = {{(PW-EW-1){mag[EW]}}, mag};
    if (neg) begin
      wide = ~wide;
    end
    pp = wide << SHIFT;
  end
endmodule

module radix8_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);
  localparam int EW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH;
  localparam int NGRP = EW / 3;

  typedef struct packed {
    logic [EW-1:0]    m;
    logic [EW-1:0]    m3;
    logic [WIDTH-1:0] q;
  } s1_t;

  function automatic logic [PW-1:0] csa_s(input logic [PW-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [PW-1:0] csa_c(input logic [PW-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  s1_t            s1_d, s1_q;
  logic           vld1_d, vld1_q;
  logic [PW-1:0]  product_d, product_q;
  logic           out_vld_d, out_vld_q;

  logic [EW-1:0]  m_ext;
  logic [EW-1:0]  m3_sum;

  assign m_ext = {{(EW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};

  rb8_ks_adder #(.W(EW)) u_ks_3m (
    .a   (m_ext),
    .b   ({m_ext[EW-2:0], 1'b0}),
    .cin (1'b0),
    .sum (m3_sum)
  );

  always_comb begin
    s1_d.m  = m_ext;
    s1_d.m3 = m3_sum;
    s1_d.q  = multiplier;
    vld1_d  = in_valid;
  end

  // Booth scan string: sign-extended Q with the implicit q[-1]=0 at bit 0.
  logic [EW:0]     qx;
  logic [PW-1:0]   pp [NGRP];
  logic [NGRP-1:0] neg;

  assign qx = {{(EW-WIDTH){s1_q.q[WIDTH-1]}}, s1_q.q, 1'b0};

  for (genvar i = 0; i < NGRP; i++) begin : g_row
    rb8_booth_row #(.EW(EW), .PW(PW), .SHIFT(3*i)) u_row (
      .m   (s1_q.m),
      .m3  (s1_q.m3),
      .grp (qx[3*i+3 -: 4]),
      .pp  (pp[i]),
      .neg (neg[i])
    );
  end

  logic [PW-1:0] corr;
  logic [PW-1:0] s1w, c1w, s2w, c2w, s3w, c3w, s4w, c4w, s5w, c5w;
  logic [PW-1:0] sum_w;

  // Seven operands (six rows plus the +1 negation word) squeezed to two by 3:2 compressors.
  always_comb begin
    corr = '0;
    for (int i = 0; i < NGRP; i++) begin
      corr[3*i] = neg[i];
    end
    s1w = csa_s(pp[0], pp[1], pp[2]);
    c1w = csa_c(pp[0], pp[1], pp[2]);
    s2w = csa_s(pp[3], pp[4], pp[5]);
    c2w = csa_c(pp[3], pp[4], pp[5]);
    s3w = csa_s(s1w, c1w, s2w);
    c3w = csa_c(s1w, c1w, s2w);
    s4w = csa_s(s3w, c3w, c2w);
    c4w = csa_c(s3w, c3w, c2w);
    s5w = csa_s(s4w, c4w, corr);
    c5w = csa_c(s4w, c4w, corr);
  end

  rb8_ks_adder #(.W(PW)) u_ks_sum (
    .a   (s5w),
    .b   (c5w),
    .cin (1'b0),
    .sum (sum_w)
  );

  always_comb begin
    product_d = sum_w;
    out_vld_d = vld1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      vld1_q    <= 1'b0;
      product_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      vld1_q    <= vld1_d;
      product_q <= product_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign product   = product_q;
  assign out_valid = out_vld_q;
endmodule

// File: tb/tb_radix8_booth_multiplier.sv
// Directed and randomized bench for radix8_booth_multiplier against an arithmetic reference pipeline.
module tb_radix8_booth_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        out_valid;
  logic [31:0] product;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: two-deep delay line of (valid, exact signed product).
  logic        mv1, mv2;
  logic [31:0] mp1, mp2;

  radix8_booth_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mv1 = 1'b0; mv2 = 1'b0;
    mp1 = '0;   mp2 = '0;
  endtask

  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b);
    in_valid     = v;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    mv2 = mv1;
    mp2 = mp1;
    mv1 = v;
    mp1 = golden(a, b);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, mv2});
    check("product", product, mp2);
  endtask

  task automatic reset_hold(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_valid     = 1'($urandom);
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_product", product, 32'd0);
    end
    model_clear();
    rst = 1'b0;
  endtask

  task automatic rst_pulse();
    in_valid     = 1'b1;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    rst = 1'b1;
    #1;
    check("midrst_async_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_async_product", product, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_hold_product", product, 32'd0);
    model_clear();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          d_a   [7] = '{3, 4660, -1, 12345, -32768, -32768, 32767};
  int          d_b   [7] = '{2, 0, -1, -6789, -32768, 32767, 32767};
  int          d_exp [7] = '{6, 0, 1, -83810205, 1073741824, -1073709056, 1073676289};
  logic [15:0] m_list[4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

  initial begin
    logic [18:0] qx;
    model_clear();
    in_valid = 1'b0; multiplicand = '0; multiplier = '0;
    reset_hold(5);

    // First valid pair right after release: model checks the 2-edge valid latency.
    cycle(1'b1, 16'd7, 16'd9);
    cycle(1'b0, 16'd0, 16'd0);
    cycle(1'b0, 16'd0, 16'd0);

    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 16'(d_a[k]), 16'(d_b[k]));
      cycle(1'b0, 16'd0, 16'd0);
      check($sformatf("directed%0d", k), product, 32'(d_exp[k]));
    end

    for (int k = 0; k < 200; k++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom));
    end

    rst_pulse();
    for (int k = 0; k < 60; k++) begin
      cycle(1'($urandom), 16'($urandom), 16'($urandom));
    end

    for (int pos = 0; pos < 6; pos++) begin
      for (int pat = 0; pat < 16; pat++) begin
        for (int mi = 0; mi < 4; mi++) begin
          qx = 19'($urandom);
          qx[0] = 1'b0;
          qx[3*pos+3 -: 4] = 4'(pat);
          cycle(1'b1, m_list[mi], qx[16:1]);
        end
      end
    end

    cycle(1'b1, 16'h8000, 16'h0000);
    cycle(1'b1, 16'h0000, 16'h8000);
    cycle(1'b0, 16'd0, 16'd0);
    cycle(1'b0, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
